// File: rtl/mac_pkg.sv
// Shared types and arithmetic helpers for the MAC lane array.
// sat_add: accumulator add with clamp/wrap; narrow: shift and fit to result width.
package mac_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_WEIGHT_W = 8;
    localparam int PROD_W       = DEF_DATA_W + DEF_WEIGHT_W;

    // val is the fitted value, sign/zero-extended to 64 bits
    typedef struct packed {
        logic [63:0] val;
        logic        ovf;
    } res_t;

    // Fit a 64-bit value into w bits: clamp when sat, else wrap.
    // ovf only reports when clamping is active.
    function automatic res_t fit(
        input logic [63:0] x,
        input int          w,
        input bit          sgn,
        input bit          sat
    );
        logic [63:0] maxv;
        logic [63:0] minv;
        logic [63:0] mask;
        logic [63:0] low;
        logic [63:0] wrapped;
        logic        hi;
        logic        lo;
        res_t        r;
        mask = (64'd1 << w) - 64'd1;
        if (sgn) begin
            maxv = (64'd1 << (w - 1)) - 64'd1;
            minv = ~maxv;
            hi   = $signed(x) > $signed(maxv);
            lo   = $signed(x) < $signed(minv);
        end else begin
            maxv = mask;
            minv = 64'd0;
            hi   = x > maxv;
            lo   = 1'b0;
        end
        low = x & mask;
        if (sgn && low[w-1])
            wrapped = low | ~mask;
        else
            wrapped = low;
        r.ovf = sat && (hi || lo);
        if (!sat)
            r.val = wrapped;
        else if (hi)
            r.val = maxv;
        else if (lo)
            r.val = minv;
        else
            r.val = x;
        return r;
    endfunction

    function automatic res_t sat_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input int          w,
        input bit          sgn,
        input bit          sat
    );
        return fit(a + b, w, sgn, sat);
    endfunction

    // Operand is already extended, so >>> is correct for both modes
    function automatic res_t narrow(
        input logic [63:0] x,
        input int          shift,
        input int          w,
        input bit          sgn,
        input bit          sat
    );
        logic [63:0] s;
        s = $signed(x) >>> shift;
        return fit(s, w, sgn, sat);
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: S1 product register, accumulator, sticky saturation bit, result.
// Ports: clk, reset, stall, take, en, s1_valid, s1_last, data, weight -> out, sat_flag.
module mac_lane
    import mac_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int WEIGHT_W  = 8,
    parameter int ACC_W     = 24,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0,
    parameter int SIGNED    = 1,
    parameter int SAT       = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                take,
    input  logic                en,
    input  logic                s1_valid,
    input  logic                s1_last,
    input  logic [DATA_W-1:0]   data,
    input  logic [WEIGHT_W-1:0] weight,
    output logic [OUT_W-1:0]    out,
    output logic                sat_flag
);

    localparam int PW = DATA_W + WEIGHT_W;

    logic [PW-1:0]    prod;
    logic [PW-1:0]    prod_d;
    logic [ACC_W-1:0] acc;
    logic             sticky;
    logic [63:0]      acc_x;
    logic [63:0]      prod_x;
    res_t             add_r;
    res_t             nar_r;

    always_comb begin
        prod_d = '0;
        acc_x  = '0;
        prod_x = '0;
        if (take && en) begin
            if (SIGNED != 0)
                prod_d = PW'($signed(data)) * PW'($signed(weight));
            else
                prod_d = PW'(data) * PW'(weight);
        end
        if (SIGNED != 0) begin
            acc_x  = 64'($signed(acc));
            prod_x = 64'($signed(prod));
        end else begin
            acc_x  = 64'(acc);
            prod_x = 64'(prod);
        end
        add_r = sat_add(acc_x, prod_x, ACC_W, SIGNED != 0, SAT != 0);
        nar_r = narrow(add_r.val, OUT_SHIFT, OUT_W, SIGNED != 0, SAT != 0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod     <= '0;
            acc      <= '0;
            sticky   <= 1'b0;
            out      <= '0;
            sat_flag <= 1'b0;
        end else if (!stall) begin
            prod <= prod_d;
            if (s1_valid) begin
                if (s1_last) begin
                    acc      <= '0;
                    sticky   <= 1'b0;
                    out      <= nar_r.val[OUT_W-1:0];
                    sat_flag <= sticky | add_r.ovf | nar_r.ovf;
                end else begin
                    acc    <= add_r.val[ACC_W-1:0];
                    sticky <= sticky | add_r.ovf;
                end
            end
        end
    end

endmodule

// File: rtl/mac_lane_array.sv
// N-lane multiply-accumulate array with valid/ready input and output handshakes.
// Ports: clk, reset, in_valid/in_ready/in_last, lane_en, datas, weights, out_valid/out_ready, outs, sat_flags.
module mac_lane_array
    import mac_pkg::*;
#(
    parameter int NUM_LANES = 8,
    parameter int DATA_W    = 8,
    parameter int WEIGHT_W  = 8,
    parameter int ACC_W     = 24,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0,
    parameter int SIGNED    = 1,
    parameter int SAT       = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_last,
    input  logic [NUM_LANES-1:0]          lane_en,
    input  logic [DATA_W*NUM_LANES-1:0]   datas,
    input  logic [WEIGHT_W*NUM_LANES-1:0] weights,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W*NUM_LANES-1:0]    outs,
    output logic [NUM_LANES-1:0]          sat_flags
);

    logic stall;
    logic take;
    logic s1_valid;
    logic s1_last;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign take     = in_valid && in_ready;

    // When not stalled, a pending result is either consumed or replaced,
    // so out_valid simply follows a completing last beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            s1_valid  <= take;
            s1_last   <= take && in_last;
            out_valid <= s1_valid && s1_last;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mac_lane #(
            .DATA_W   (DATA_W),
            .WEIGHT_W (WEIGHT_W),
            .ACC_W    (ACC_W),
            .OUT_W    (OUT_W),
            .OUT_SHIFT(OUT_SHIFT),
            .SIGNED   (SIGNED),
            .SAT      (SAT)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .stall   (stall),
            .take    (take),
            .en      (lane_en[i]),
            .s1_valid(s1_valid),
            .s1_last (s1_last),
            .data    (datas[DATA_W*i +: DATA_W]),
            .weight  (weights[WEIGHT_W*i +: WEIGHT_W]),
            .out     (outs[OUT_W*i +: OUT_W]),
            .sat_flag(sat_flags[i])
        );
    end

endmodule

// File: tb/tb_mac_lane_array.sv
// Directed bench for mac_lane_array: default saturating instance plus a wrapping twin.
// Both instances see the same stimulus; the wrapping one is checked in the saturation test.
module tb_mac_lane_array;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_last;
    logic [7:0]   lane_en;
    logic [63:0]  datas;
    logic [63:0]  weights;
    logic         out_ready;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] outs;
    logic [7:0]   sat_flags;
    logic         in_ready_w;
    logic         out_valid_w;
    logic [127:0] outs_w;
    logic [7:0]   sat_flags_w;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mac_lane_array dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .lane_en  (lane_en),
        .datas    (datas),
        .weights  (weights),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .outs     (outs),
        .sat_flags(sat_flags)
    );

    mac_lane_array #(.SAT(0)) dut_w (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready_w),
        .in_last  (in_last),
        .lane_en  (lane_en),
        .datas    (datas),
        .weights  (weights),
        .out_valid(out_valid_w),
        .out_ready(out_ready),
        .outs     (outs_w),
        .sat_flags(sat_flags_w)
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] lv(input int lane, input logic [15:0] v);
        return 128'(v) << (16 * lane);
    endfunction

    task automatic put(input int lane, input int d, input int w, input logic last);
        datas                  = '0;
        weights                = '0;
        datas[8*lane +: 8]     = 8'(d);
        weights[8*lane +: 8]   = 8'(w);
        lane_en                = '1;
        in_valid               = 1'b1;
        in_last                = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        lane_en   = '1;
        datas     = '0;
        weights   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_outs", outs, 128'd0);
        check("rst_sat", 128'(sat_flags), 128'd0);

        // 3-beat frame: 2*5 + 3*5 + (-4)*5 = 5
        put(0, 2, 5, 1'b0);
        put(0, 3, 5, 1'b0);
        put(0, -4, 5, 1'b1);
        check("t1_not_yet", 128'(out_valid), 128'd0);
        tick();
        check("t1_valid", 128'(out_valid), 128'd1);
        check("t1_outs", outs, lv(0, 16'd5));
        check("t1_sat", 128'(sat_flags), 128'd0);
        tick();
        check("t1_drop", 128'(out_valid), 128'd0);

        // back-to-back single-beat frames
        put(1, 7, 9, 1'b1);
        check("t2_ir0", 128'(in_ready), 128'd1);
        put(1, -8, 8, 1'b1);
        check("t2_v0", 128'(out_valid), 128'd1);
        check("t2_o0", outs, lv(1, 16'd63));
        check("t2_ir1", 128'(in_ready), 128'd1);
        tick();
        check("t2_v1", 128'(out_valid), 128'd1);
        check("t2_o1", outs, lv(1, 16'hFFC0));
        check("t2_ir2", 128'(in_ready), 128'd1);
        tick();
        check("t2_drop", 128'(out_valid), 128'd0);

        // backpressure with a third beat waiting at the input
        out_ready = 1'b0;
        put(2, 4, 4, 1'b1);
        put(2, 5, 5, 1'b1);
        check("t3_v", 128'(out_valid), 128'd1);
        check("t3_o", outs, lv(2, 16'd16));
        check("t3_ir", 128'(in_ready), 128'd0);
        datas            = '0;
        weights          = '0;
        datas[23:16]     = 8'd6;
        weights[23:16]   = 8'd6;
        in_valid         = 1'b1;
        in_last          = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_ir", 128'(in_ready), 128'd0);
            check("t3_hold_o", outs, lv(2, 16'd16));
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("t3_v2", 128'(out_valid), 128'd1);
        check("t3_o2", outs, lv(2, 16'd25));
        tick();
        check("t3_v3", 128'(out_valid), 128'd1);
        check("t3_o3", outs, lv(2, 16'd36));
        tick();
        check("t3_drop", 128'(out_valid), 128'd0);

        // 4 * 127*127 = 64516: clamps to 32767, wraps to 0xFC04
        put(3, 127, 127, 1'b0);
        put(3, 127, 127, 1'b0);
        put(3, 127, 127, 1'b0);
        put(3, 127, 127, 1'b1);
        tick();
        check("t4_sat_o", outs, lv(3, 16'h7FFF));
        check("t4_sat_f", 128'(sat_flags), 128'h08);
        check("t4_wrap_o", outs_w, lv(3, 16'hFC04));
        check("t4_wrap_f", 128'(sat_flags_w), 128'd0);
        tick();

        // only lane 0 enabled: 2 * 10*10
        datas    = {8{8'd10}};
        weights  = {8{8'd10}};
        lane_en  = 8'h01;
        in_valid = 1'b1;
        in_last  = 1'b0;
        tick();
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        lane_en  = '1;
        tick();
        check("t5_v", 128'(out_valid), 128'd1);
        check("t5_o", outs, lv(0, 16'd200));
        tick();

        // reset mid-frame discards 200 of partial sum
        put(0, 50, 2, 1'b0);
        put(0, 50, 2, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_ir", 128'(in_ready), 128'd1);
        check("t6_v", 128'(out_valid), 128'd0);
        check("t6_o", outs, 128'd0);
        check("t6_sat", 128'(sat_flags), 128'd0);
        in_last = 1'b1;
        tick();
        in_last = 1'b0;
        tick();
        check("t6_lonely_last", 128'(out_valid), 128'd0);
        put(0, 3, 3, 1'b1);
        tick();
        check("t6_v2", 128'(out_valid), 128'd1);
        check("t6_o2", outs, lv(0, 16'd9));
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
